// File: rtl/debug_pkg.sv
// Shared definitions for the SPI debug command receiver.
// Holds the default field widths, the command opcode encoding and the
// receive FSM state type used by spi_debug_cmd.
package debug_pkg;

    localparam int OPC_W_DEF = 8;
    localparam int ARG_W_DEF = 16;

    typedef enum logic [7:0] {
        OPC_NOP     = 8'h00,
        OPC_HALT    = 8'h01,
        OPC_RUN     = 8'h02,
        OPC_STEP    = 8'h03,
        OPC_SET_BP  = 8'h04,
        OPC_CLR_BP  = 8'h05,
        OPC_SET_RST = 8'h06
    } dbg_opc_e;

    typedef enum logic [1:0] {
        SH_OPC = 2'd0,
        SH_ARG = 2'd1,
        DONE   = 2'd2
    } rx_state_e;

endpackage

// File: rtl/spi_rx_shift.sv
// Serial receive front end: an MSB-first shift register plus a saturating
// bit counter, both clocked on the SPI sampling edge.
// Ports:
//   sclk_i  - SPI clock, bits sampled on its rising edge
//   clr_i   - asynchronous clear, active-high (frame boundary / abort)
//   si_i    - serial data in
//   shift_o - bits received so far, newest bit in bit 0
//   cnt_o   - number of bits received, saturates at FRAME_LEN
module spi_rx_shift #(
    parameter int FRAME_LEN = 24,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic                 sclk_i,
    input  logic                 clr_i,
    input  logic                 si_i,
    output logic [FRAME_LEN-1:0] shift_o,
    output logic [CNT_W-1:0]     cnt_o
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);

    logic [FRAME_LEN-1:0] shift_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 active;

    // Once a full frame has arrived further bits are neither counted nor
    // shifted, so the frame contents stay put until the clear.
    assign active = (cnt_reg != CNT_FULL);

    always_ff @(posedge sclk_i or posedge clr_i) begin
        if (clr_i) begin
            cnt_reg   <= '0;
            shift_reg <= '0;
        end else if (active) begin
            cnt_reg   <= cnt_reg + 1'b1;
            shift_reg <= {shift_reg[FRAME_LEN-2:0], si_i};
        end
    end

    assign shift_o = shift_reg;
    assign cnt_o   = cnt_reg;

endmodule

// File: rtl/spi_debug_cmd.sv
// SPI (mode 3) debug command slave. Receives fixed-length frames of
// opcode + operand, MSB first, and executes the command on the very edge
// that samples the last bit of the frame.
// Ports:
//   sclk_i        - SPI clock from the debugger, the only clock
//   resetb        - asynchronous reset, active-low
//   csb_i         - chip select, active-low; high clears the receiver
//   si_i          - serial data in
//   halt_o        - CPU halt request (level)
//   step_tgl_o    - single-step request, toggles once per accepted step
//   bp_en_o       - breakpoint enable
//   bp_addr_o     - breakpoint PC address
//   cpu_rst_req_o - CPU reset request (level, active-high)
//   cmd_err_o     - last completed frame had an unknown opcode
//   cmd_cnt_o     - executed (non-NOP, valid) command count, wraps
module spi_debug_cmd
    import debug_pkg::*;
#(
    parameter int OPC_W = OPC_W_DEF,
    parameter int ARG_W = ARG_W_DEF
) (
    input  logic        sclk_i,
    input  logic        resetb,
    input  logic        csb_i,
    input  logic        si_i,
    output logic        halt_o,
    output logic        step_tgl_o,
    output logic        bp_en_o,
    output logic [15:0] bp_addr_o,
    output logic        cpu_rst_req_o,
    output logic        cmd_err_o,
    output logic [7:0]  cmd_cnt_o
);

    localparam int FRAME_LEN = OPC_W + ARG_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] OPC_LAST   = CNT_W'(OPC_W - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);

    logic                 abort_set;
    logic                 abort_reg;
    logic                 rx_clr;
    logic [FRAME_LEN-1:0] shift_w;
    logic [CNT_W-1:0]     bit_cnt;
    logic [FRAME_LEN-1:0] frame_w;
    logic [OPC_W-1:0]     opc_w;
    logic [ARG_W-1:0]     arg_w;
    logic                 frame_done;
    logic                 shift_msb_unused;

    rx_state_e state_reg, state_next;

    logic        halt_reg,    halt_next;
    logic        step_reg,    step_next;
    logic        bp_en_reg,   bp_en_next;
    logic [15:0] bp_addr_reg, bp_addr_next;
    logic        rst_req_reg, rst_req_next;
    logic        err_reg,     err_next;
    logic [7:0]  cnt_reg,     cnt_next;

    // A reset that lands inside a frame poisons the rest of that frame:
    // the flag is raised only while csb_i is low and is dropped when the
    // debugger deselects, so a reset between frames never loses a frame.
    assign abort_set = ~resetb & ~csb_i;

    always_ff @(posedge sclk_i or posedge csb_i or posedge abort_set) begin
        if (csb_i) begin
            abort_reg <= 1'b0;
        end else if (abort_set) begin
            abort_reg <= 1'b1;
        end else begin
            abort_reg <= abort_reg;
        end
    end

    assign rx_clr = csb_i | abort_reg | ~resetb;

    spi_rx_shift #(
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) u_rx (
        .sclk_i  (sclk_i),
        .clr_i   (rx_clr),
        .si_i    (si_i),
        .shift_o (shift_w),
        .cnt_o   (bit_cnt)
    );

    // Decode sees the frame including the bit being sampled right now, so
    // the command takes effect on the last bit's edge. The oldest shift
    // register bit would only be shifted out here and is not needed.
    assign frame_w          = {shift_w[FRAME_LEN-2:0], si_i};
    assign shift_msb_unused = shift_w[FRAME_LEN-1];
    assign opc_w            = frame_w[FRAME_LEN-1 -: OPC_W];
    assign arg_w            = frame_w[ARG_W-1:0];
    assign frame_done       = (state_reg == SH_ARG) && (bit_cnt == FRAME_LAST);

    always_ff @(posedge sclk_i or posedge rx_clr) begin
        if (rx_clr) begin
            state_reg <= SH_OPC;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SH_OPC:  if (bit_cnt == OPC_LAST)   state_next = SH_ARG;
            SH_ARG:  if (bit_cnt == FRAME_LAST) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = SH_OPC;
        endcase
    end

    always_comb begin
        halt_next    = halt_reg;
        step_next    = step_reg;
        bp_en_next   = bp_en_reg;
        bp_addr_next = bp_addr_reg;
        rst_req_next = rst_req_reg;
        err_next     = err_reg;
        cnt_next     = cnt_reg;
        if (frame_done) begin
            err_next = 1'b0;
            cnt_next = cnt_reg + 8'd1;
            case (opc_w)
                OPC_W'(OPC_NOP):     cnt_next = cnt_reg;
                OPC_W'(OPC_HALT):    halt_next = 1'b1;
                OPC_W'(OPC_RUN):     halt_next = 1'b0;
                // Stepping a running CPU is meaningless; still counted.
                OPC_W'(OPC_STEP):    step_next = step_reg ^ halt_reg;
                OPC_W'(OPC_SET_BP): begin
                    bp_addr_next = 16'(arg_w);
                    bp_en_next   = 1'b1;
                end
                OPC_W'(OPC_CLR_BP):  bp_en_next = 1'b0;
                OPC_W'(OPC_SET_RST): rst_req_next = arg_w[0];
                default: begin
                    err_next = 1'b1;
                    cnt_next = cnt_reg;
                end
            endcase
        end
    end

    always_ff @(posedge sclk_i or negedge resetb) begin
        if (!resetb) begin
            halt_reg    <= 1'b0;
            step_reg    <= 1'b0;
            bp_en_reg   <= 1'b0;
            bp_addr_reg <= 16'h0000;
            rst_req_reg <= 1'b0;
            err_reg     <= 1'b0;
            cnt_reg     <= 8'h00;
        end else begin
            halt_reg    <= halt_next;
            step_reg    <= step_next;
            bp_en_reg   <= bp_en_next;
            bp_addr_reg <= bp_addr_next;
            rst_req_reg <= rst_req_next;
            err_reg     <= err_next;
            cnt_reg     <= cnt_next;
        end
    end

    assign halt_o        = halt_reg;
    assign step_tgl_o    = step_reg;
    assign bp_en_o       = bp_en_reg;
    assign bp_addr_o     = bp_addr_reg;
    assign cpu_rst_req_o = rst_req_reg;
    assign cmd_err_o     = err_reg;
    assign cmd_cnt_o     = cnt_reg;

endmodule
